// File: rtl/usart_tx_sched.sv
// usart_tx_sched: programs the i8251 USART after reset, then shares its transmitter between two
// byte requesters, polling TxRDY before every data write. Optional macro: USART_TX_SCHED_FIXED_PRIO_EN.
module usart_tx_sched #(
  parameter logic [7:0] MODE_WORD  = 8'h4E,
  parameter logic [7:0] CMD_WORD   = 8'h15,
  parameter int         STROBE_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       cd,
  output logic [7:0] dout,
  input  logic [7:0] din,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy
);

  // state | meaning: INIT program USART | IDLE wait for request | ARB grant+latch | POLL status read | WRITE data write
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ARB   = 3'd2;
  localparam logic [2:0] ST_POLL  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [4:0] SLOT_LAST = 5'(STROBE_LEN + 2);

  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       act_q, act_d;
  logic [2:0] init_idx_q, init_idx_d;
  logic       init_done_q, init_done_d;
  logic       txrdy_q, txrdy_d;
  logic       grant_q, grant_d;
  logic [7:0] byte_q, byte_d;

  logic       grant_sel;
  logic       slot_on;
  logic       gap;
  logic       strobe;
  logic [7:0] init_word;
  logic       unused_din;

  assign unused_din = ^din[7:1];

`ifdef USART_TX_SCHED_FIXED_PRIO_EN
  assign grant_sel = !req0_valid;
`else
  logic last_q, last_d;

  // last_q names the requester served most recently; the other one wins a contention
  assign grant_sel = !(req0_valid && (!req1_valid || last_q));
  assign last_d    = (state_q == ST_WRITE && gap) ? grant_q : last_q;

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  // cnt_q counts down through a slot: SLOT_LAST = SETUP, 1 = HOLD, 0 = GAP, strobe in between
  assign slot_on = act_q && (cnt_q != 5'd0);
  assign gap     = act_q && (cnt_q == 5'd0);
  assign strobe  = slot_on && (cnt_q != 5'd1) && (cnt_q != SLOT_LAST);

  always_comb begin
    case (init_idx_q)
      3'd3:    init_word = 8'h40;
      3'd4:    init_word = MODE_WORD;
      3'd5:    init_word = CMD_WORD;
      default: init_word = 8'h00;
    endcase
  end

  assign cs_n       = !slot_on;
  assign rd_n       = !(strobe && state_q == ST_POLL);
  assign wr_n       = !(strobe && state_q != ST_POLL);
  assign cd         = act_q && (state_q != ST_WRITE);
  assign dout       = (act_q && state_q == ST_INIT)  ? init_word :
                      (act_q && state_q == ST_WRITE) ? byte_q    : 8'h00;
  assign busy       = slot_on || (state_q == ST_ARB);
  assign req0_ready = gap && (state_q == ST_WRITE) && !grant_q;
  assign req1_ready = gap && (state_q == ST_WRITE) &&  grant_q;
  assign init_done  = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    txrdy_d     = txrdy_q;
    grant_d     = grant_q;
    byte_d      = byte_q;

    if (slot_on) cnt_d = cnt_q - 5'd1;
    if (state_q == ST_POLL && act_q && cnt_q == 5'd2) txrdy_d = din[0];

    case (state_q)
      ST_INIT: begin
        if (!act_q) begin
          act_d = 1'b1;
          cnt_d = SLOT_LAST;
        end else if (gap) begin
          if (init_idx_q == 3'd5) begin
            state_d     = ST_IDLE;
            act_d       = 1'b0;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            cnt_d      = SLOT_LAST;
          end
        end
      end
      ST_IDLE: begin
        if (req0_valid || req1_valid) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (req0_valid || req1_valid) begin
          grant_d = grant_sel;
          byte_d  = grant_sel ? req1_data : req0_data;
          state_d = ST_POLL;
          act_d   = 1'b1;
          cnt_d   = SLOT_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POLL: begin
        if (gap) begin
          state_d = txrdy_q ? ST_WRITE : ST_POLL;
          cnt_d   = SLOT_LAST;
        end
      end
      ST_WRITE: begin
        if (gap) begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        act_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= 5'd0;
      act_q       <= 1'b0;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      txrdy_q     <= 1'b0;
      grant_q     <= 1'b0;
      byte_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      txrdy_q     <= txrdy_d;
      grant_q     <= grant_d;
      byte_q      <= byte_d;
    end
  end

endmodule

// File: tb/tb_usart_tx_sched.sv
// Bench for usart_tx_sched: a bus monitor turns strobes into access records that are
// scoreboarded against expected USART traffic and requester ready pulses.
module tb_usart_tx_sched;
  localparam int STROBE_LEN = 2;
  localparam int SLOT       = STROBE_LEN + 3;
  localparam int INIT_CYC   = 6 * SLOT;
  localparam int BEST_LAT   = 2 * STROBE_LEN + 8;

  typedef struct packed {
    logic       is_wr;
    logic       cd;
    logic [7:0] data;
    logic [3:0] len;
    logic       cs_ok;
  } acc_t;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       busy;
  } rdy_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n, wr_n, rd_n, cd;
  logic [7:0] dout, din;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, init_done, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int zero_polls = 0;

  acc_t mon_q[$];
  acc_t exp_q[$];
  rdy_t rdy_q[$];
  rdy_t exp_rdy_q[$];
  int   rdy_cyc_q[$];

  usart_tx_sched #(.MODE_WORD(8'h4E), .CMD_WORD(8'h15), .STROBE_LEN(STROBE_LEN)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .cd(cd),
    .dout(dout), .din(din),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // USART status: TxRDY stays low for the next zero_polls status reads
  assign din = {7'h21, zero_polls == 0};

  function automatic acc_t mk_acc(input logic is_wr, input logic c, input logic [7:0] d);
    acc_t a;
    a.is_wr = is_wr; a.cd = c; a.data = d; a.len = 4'(STROBE_LEN); a.cs_ok = 1'b1;
    return a;
  endfunction

  function automatic rdy_t mk_rdy(input logic id, input logic [7:0] d);
    rdy_t r;
    r.id = id; r.data = d; r.busy = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] init_word(input int i);
    case (i)
      3:       return 8'h40;
      4:       return 8'h4E;
      5:       return 8'h15;
      default: return 8'h00;
    endcase
  endfunction

  // Bus monitor
  int         wr_len = 0, rd_len = 0;
  logic       wr_cd_s = 1'b0, rd_cd_s = 1'b0, wr_cs_s = 1'b0, rd_cs_s = 1'b0, prev_cs_n = 1'b1;
  logic [7:0] wr_data_s = 8'h00, last_wr = 8'h00;

  always @(negedge clk) begin
    acc_t a;
    rdy_t r;
    if (!wr_n) begin
      if (wr_len == 0) begin
        wr_cd_s = cd; wr_data_s = dout; wr_cs_s = !prev_cs_n && !cs_n;
      end else begin
        wr_cs_s = wr_cs_s && !cs_n;
      end
      wr_len++;
    end else if (wr_len != 0) begin
      a.is_wr = 1'b1; a.cd = wr_cd_s; a.data = wr_data_s; a.len = 4'(wr_len);
      a.cs_ok = wr_cs_s && !cs_n && (cd == wr_cd_s) && (dout == wr_data_s);
      mon_q.push_back(a);
      last_wr = wr_data_s;
      wr_len = 0;
    end
    if (!rd_n) begin
      if (rd_len == 0) begin
        rd_cd_s = cd; rd_cs_s = !prev_cs_n && !cs_n;
      end else begin
        rd_cs_s = rd_cs_s && !cs_n;
      end
      rd_len++;
    end else if (rd_len != 0) begin
      a.is_wr = 1'b0; a.cd = rd_cd_s; a.data = 8'h00; a.len = 4'(rd_len);
      a.cs_ok = rd_cs_s && !cs_n && (cd == rd_cd_s);
      mon_q.push_back(a);
      if (zero_polls > 0) zero_polls--;
      rd_len = 0;
    end
    if (req0_ready) begin
      r.id = 1'b0; r.data = last_wr; r.busy = busy;
      rdy_q.push_back(r); rdy_cyc_q.push_back(cyc);
    end
    if (req1_ready) begin
      r.id = 1'b1; r.data = last_wr; r.busy = busy;
      rdy_q.push_back(r); rdy_cyc_q.push_back(cyc);
    end
    prev_cs_n = cs_n;
  end

  // Returns #1 after the clock edge that ends the GAP cycle of the n-th ready pulse.
  task automatic wait_ready(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (rdy_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cs_n, wr_n, rd_n} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 111", {cs_n, wr_n, rd_n});
    end
    n_checks++;
    if ({cd, dout} !== 9'h000) begin
      n_fail++; $display("FAIL reset_cd_dout: got cd=%b dout=%h required cd=0 dout=00", cd, dout);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({init_done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_done_busy: got %b required 00", {init_done, busy});
    end
  endtask

  // Releases reset and checks the programming sequence; done_cyc is the first IDLE cycle.
  task automatic test_init(output int done_cyc);
    int   t0;
    acc_t e, g;
    @(posedge clk); #1;
    mon_q.delete(); rdy_q.delete(); rdy_cyc_q.delete(); exp_q.delete(); exp_rdy_q.delete();
    reset = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk_acc(1'b1, 1'b1, init_word(i)));
    done_cyc = -1;
    for (int k = 0; k < 4 * INIT_CYC && done_cyc < 0; k++) begin
      @(negedge clk);
      if (init_done === 1'b1) done_cyc = cyc;
    end
    n_checks++;
    if (done_cyc - (t0 + 1) != INIT_CYC) begin
      n_fail++; $display("FAIL init_done_time: got %0d required %0d", done_cyc - (t0 + 1), INIT_CYC);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (mon_q.size() > 0) ? mon_q.pop_front() : '0;
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL init_access: got %h required %h", g, e);
      end
    end
    n_checks++;
    if (mon_q.size() != 0 || rdy_q.size() != 0) begin
      n_fail++;
      $display("FAIL init_extra: got %0d accesses %0d readies required 0 0", mon_q.size(), rdy_q.size());
      mon_q.delete(); rdy_q.delete(); rdy_cyc_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    acc_t e, g;
    rdy_t er, gr;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h00));
      exp_q.push_back(mk_acc(1'b1, 1'b0, (i % 2 == 0) ? 8'h11 : 8'h22));
      exp_rdy_q.push_back(mk_rdy((i % 2) != 0, (i % 2 == 0) ? 8'h11 : 8'h22));
    end
    zero_polls = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
    wait_ready(4, 200, ok);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d readies required 4", rdy_q.size());
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (rdy_cyc_q.size() < 4 || rdy_cyc_q[i] - rdy_cyc_q[i-1] != 4 + 2 * STROBE_LEN + 4) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d cycles required %0d", (rdy_cyc_q.size() < 4) ? -1 : rdy_cyc_q[i] - rdy_cyc_q[i-1], 4 + 2 * STROBE_LEN + 4);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (mon_q.size() > 0) ? mon_q.pop_front() : '0;
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL b2b_access: got %h required %h", g, e);
      end
    end
    while (exp_rdy_q.size() > 0) begin
      er = exp_rdy_q.pop_front();
      gr = (rdy_q.size() > 0) ? rdy_q.pop_front() : '0;
      n_checks++;
      if (gr !== er) begin
        n_fail++; $display("FAIL b2b_ready: got %h required %h", gr, er);
      end
    end
    n_checks++;
    if (mon_q.size() != 0 || rdy_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_extra: got %0d accesses %0d readies required 0 0", mon_q.size(), rdy_q.size());
    end
    mon_q.delete(); rdy_q.delete(); rdy_cyc_q.delete();
  endtask

  task automatic test_fixed_prio();
    bit   ok, ok2;
    acc_t e, g;
    rdy_t er, gr;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h00));
      exp_q.push_back(mk_acc(1'b1, 1'b0, (i < 3) ? 8'h11 : 8'h22));
      exp_rdy_q.push_back(mk_rdy(i == 3, (i < 3) ? 8'h11 : 8'h22));
    end
    zero_polls = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
    wait_ready(3, 200, ok);
    req0_valid = 1'b0;
    wait_ready(4, 100, ok2);
    req1_valid = 1'b0;
    n_checks++;
    if (!(ok && ok2)) begin
      n_fail++; $display("FAIL prio_timeout: got %0d readies required 4", rdy_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (mon_q.size() > 0) ? mon_q.pop_front() : '0;
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL prio_access: got %h required %h", g, e);
      end
    end
    while (exp_rdy_q.size() > 0) begin
      er = exp_rdy_q.pop_front();
      gr = (rdy_q.size() > 0) ? rdy_q.pop_front() : '0;
      n_checks++;
      if (gr !== er) begin
        n_fail++; $display("FAIL prio_ready: got %h required %h", gr, er);
      end
    end
    mon_q.delete(); rdy_q.delete(); rdy_cyc_q.delete();
  endtask

  // One requester, given number of not-ready polls; checks traffic and valid-to-ready latency.
  task automatic test_single(input logic id, input logic [7:0] d, input int zeros, input string nm);
    bit   ok;
    int   c, rc;
    acc_t e, g;
    rdy_t er, gr;
    for (int i = 0; i <= zeros; i++) exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h00));
    exp_q.push_back(mk_acc(1'b1, 1'b0, d));
    exp_rdy_q.push_back(mk_rdy(id, d));
    zero_polls = zeros;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    c = cyc;
    wait_ready(1, 100 + zeros * SLOT, ok);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL %s_timeout: got 0 readies required 1", nm);
    end
    rc = (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - c + 1 : -1;
    n_checks++;
    if (rc != BEST_LAT + zeros * SLOT) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", nm, rc, BEST_LAT + zeros * SLOT);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (mon_q.size() > 0) ? mon_q.pop_front() : '0;
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL %s_access: got %h required %h", nm, g, e);
      end
    end
    er = exp_rdy_q.pop_front();
    gr = (rdy_q.size() > 0) ? rdy_q.pop_front() : '0;
    n_checks++;
    if (gr !== er || rdy_q.size() != 0 || mon_q.size() != 0) begin
      n_fail++; $display("FAIL %s_ready: got %h (+%0d readies, +%0d accesses) required %h", nm, gr, rdy_q.size(), mon_q.size(), er);
    end
    mon_q.delete(); rdy_q.delete(); rdy_cyc_q.delete();
  endtask

  task automatic test_reset_mid_write();
    bit   ok;
    int   done_c, rc;
    acc_t e, g;
    rdy_t gr;
    zero_polls = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h5A;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wr_n === 1'b0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rst_write_timeout: got no write strobe required one");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cs_n, wr_n, rd_n} !== 3'b111) begin
      n_fail++; $display("FAIL rst_strobes: got %b required 111", {cs_n, wr_n, rd_n});
    end
    n_checks++;
    if ({busy, init_done} !== 2'b00) begin
      n_fail++; $display("FAIL rst_busy_done: got %b required 00", {busy, init_done});
    end
    repeat (SLOT) @(negedge clk);
    #1;
    n_checks++;
    if (rdy_q.size() != 0) begin
      n_fail++; $display("FAIL rst_no_ready: got %0d readies required 0", rdy_q.size());
    end
    test_init(done_c);
    // requester 0 kept valid through reset and INIT: served once IDLE is reached
    exp_q.push_back(mk_acc(1'b0, 1'b1, 8'h00));
    exp_q.push_back(mk_acc(1'b1, 1'b0, 8'h5A));
    wait_ready(1, 100, ok);
    req0_valid = 1'b0;
    rc = (rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - done_c + 1 : -1;
    n_checks++;
    if (rc != BEST_LAT) begin
      n_fail++; $display("FAIL rst_after_init_latency: got %0d required %0d", rc, BEST_LAT);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (mon_q.size() > 0) ? mon_q.pop_front() : '0;
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL rst_after_init_access: got %h required %h", g, e);
      end
    end
    gr = (rdy_q.size() > 0) ? rdy_q.pop_front() : '0;
    n_checks++;
    if (gr !== mk_rdy(1'b0, 8'h5A) || rdy_q.size() != 0) begin
      n_fail++; $display("FAIL rst_after_init_ready: got %h (+%0d) required %h", gr, rdy_q.size(), mk_rdy(1'b0, 8'h5A));
    end
    mon_q.delete(); rdy_q.delete(); rdy_cyc_q.delete();
  endtask

  initial begin
    int done_c;
    test_reset();
    test_init(done_c);
`ifdef USART_TX_SCHED_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_back_to_back();
`endif
    test_single(1'b0, 8'hA5, 0, "single");
    test_single(1'b1, 8'h3C, 3, "poll_retry");
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usart_tx_sched.md
# usart_tx_sched

Bus-master controller for the on-chip i8251 USART. After reset it programs the USART with the 8251 internal-reset sequence, the mode word and the command word. It then shares the USART transmitter between two byte-stream requesters, such as the tape/serial front-ends. Each granted byte is written only after polling status TxRDY.

## Interface
Parameters:
- MODE_WORD, 8'h4E, async mode word: 1 stop bit, no parity, 8 data bits, x16 clock.
- CMD_WORD, 8'h15, command word: ER, RxE, TxEN.
- STROBE_LEN, 2, cycles rd_n/wr_n are held low per access; legal range 1..15.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cs_n  out  1  USART chip select, active low.
- wr_n  out  1  USART write strobe, active low.
- rd_n  out  1  USART read strobe, active low.
- cd  out  1  USART C/D select: 1 = control/status, 0 = data.
- dout  out  8  write data to the USART.
- din  in  8  read data from the USART; status bit 0 = TxRDY.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  one-cycle pulse: byte 0 was written.
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1.
- init_done  out  1  high once USART programming is complete.
- busy  out  1  high while any bus access is in progress.

## Operation
- Access slot = SETUP (1 cycle) + STROBE (STROBE_LEN cycles) + HOLD (1 cycle) + GAP (1 cycle); total STROBE_LEN+3 cycles.
  - SETUP and HOLD: cs_n=0; cd and dout valid; strobes high.
  - STROBE: one of rd_n or wr_n is low.
  - GAP: cs_n=1.
- Read data is sampled from din on the last STROBE cycle.
- States: INIT, IDLE, ARB, POLL, WRITE.
- INIT: six control writes with cd=1, in order: 8'h00, 8'h00, 8'h00, 8'h40, MODE_WORD, CMD_WORD. Then init_done=1 and the block goes to IDLE.
- IDLE: if any reqN_valid is high, go to ARB the next cycle.
- ARB: one cycle; latch the grant and the granted byte.
  - Round-robin; the last-served pointer resets to 1, so requester 0 wins the first contention.
  - The pointer is updated only when a byte is written.
- POLL: status read slot (cd=1, rd_n strobe).
  - Sampled din[0]=1: go to WRITE.
  - Sampled din[0]=0: repeat POLL back-to-back. No timeout.
- WRITE: data slot with cd=0, wr_n strobe, dout = latched byte.
  - reqN_ready pulses for one cycle in the GAP cycle of this slot.
  - Then go to IDLE.
- Requester rule: data must stay stable while valid is high and ready is low. The byte is latched in ARB, so later changes are ignored. A requester dropping valid after ARB still gets its byte written.
- Both valid in ARB: the requester not served last wins. Only one ready pulse per WRITE slot.
- busy=1 in every slot cycle except GAP, and in ARB.

## Timing
- Reset values: cs_n=1, wr_n=1, rd_n=1, cd=0, dout=8'h00, req0_ready=0, req1_ready=0, init_done=0, busy=0. State=INIT, RR pointer=1.
- Reset asserted mid-access: all strobes and cs_n go high on the next edge. The INIT sequence restarts from its first write. Any latched byte is dropped and no ready is issued.
- First INIT SETUP cycle is the first cycle after reset deasserts.
- init_done rises 6*(STROBE_LEN+3) cycles after reset deasserts; 30 cycles at default.
- Requests raised during INIT are held off until IDLE.
- Best-case valid-to-ready latency: 1 (IDLE) + 1 (ARB) + (STROBE_LEN+3) (POLL) + (STROBE_LEN+3) (WRITE, ready in GAP) = 2*STROBE_LEN+8 cycles; 12 at default.
- Each extra not-ready poll adds STROBE_LEN+3 cycles.
- After a ready pulse, the next ARB occurs no earlier than 2 cycles later (IDLE, then ARB).

## Configuration
- USART_TX_SCHED_FIXED_PRIO_EN defined: ARB uses fixed priority, requester 0 always wins over requester 1, and the RR pointer logic is omitted.
- Undefined (default): round-robin arbitration as described above.

## Test plan
- Reset release, STROBE_LEN=2 -> six cd=1 writes 00,00,00,40,4E,15, each wr_n low for 2 cycles; init_done=1 at cycle 30.
- din[0]=1, req0_valid with 8'hA5 -> one status read, then a cd=0 write of A5; req0_ready pulses 12 cycles after valid.
- Both requesters continuously valid (0x11 / 0x22) -> writes alternate 11,22,11,22; each ready pulse aligns with its own byte.
- din[0]=0 for the first 3 status reads then 1, req1 byte 8'h3C -> 4 POLL slots then the write; ready after 12+15=27 cycles.
- reset pulsed during a WRITE STROBE -> cs_n/wr_n high next cycle, no req ready, INIT sequence restarts with 8'h00.
- USART_TX_SCHED_FIXED_PRIO_EN defined, both valid -> requester 0 served every time while valid; req1 served only after req0_valid drops.
